iter_shift_ctrl: RTL
====================

# iter_shift_ctrl

Multi-cycle shift sequencer for the execute stage. It latches an operand and shift amount, then drives a registered 1-bit shift step until the count is exhausted. It implements SLL, SRL and SRA for the ALU's shift instructions. Hazard logic stalls the pipeline on `busy` and captures `result` on the single-cycle `done` pulse.

## Interface
- `N`, 32, datapath width
- `SHW`, 5, shift-amount width; must equal log2(N)

- `clk`  input  1  rising-edge clock
- `rst`  input  1  asynchronous reset, active-high
- `start`  input  1  request; sampled only in IDLE
- `op`  input  2  00 SLL, 01 SRL, 10 SRA, 11 treated as SLL
- `operand`  input  N  value to shift; sampled with `start`
- `shamt`  input  SHW  shift amount; sampled with `start`
- `flush`  input  1  synchronous abort from pipeline flush
- `busy`  output  1  high whenever state is not IDLE
- `done`  output  1  one-cycle completion pulse
- `result`  output  N  shifted value; valid from `done`, held until the next completion

## Operation
- States: IDLE, SHIFT, DONE. Reset puts the block in IDLE.
- IDLE:
  - `start`=1 and `flush`=0: latch `operand` into `data`, `shamt` into `cnt`, `op` into `op_q`; go to SHIFT.
- SHIFT, `cnt`≠0: one step per cycle.
  - SLL: `data`={data[N-2:0],0}.
  - SRL: `data`={0,data[N-1:1]}.
  - SRA: `data`={data[N-1],data[N-1:1]}.
  - `cnt` decrements by 1.
- SHIFT, `cnt`=0: `result`<=`data`; go to DONE.
- DONE: `done`=1 for exactly this cycle; go to IDLE unconditionally.
- `start` in SHIFT or DONE is ignored, not queued.
- `flush`=1 in any state: go to IDLE next cycle.
  - No `done` pulse; `result` keeps its prior value.
  - `flush` beats `start` in the same cycle.
- `done` and `busy` are Moore outputs decoded from registered state. No combinational path from inputs to outputs.
- Reset values: `busy`=0, `done`=0, `result`=0. Internal `data`=0, `cnt`=0.
- Reset mid-operation aborts immediately; outputs take their reset values asynchronously.

## Timing
- Cycle 0 is the cycle in which `start` is high in IDLE.
- Cycle 1: SHIFT, `cnt`=k, `busy`=1.
- Base latency:
  - Shifting occurs in cycles 1..k.
  - `cnt`=0 in cycle k+1.
  - DONE (`done`=1, `result` valid) in cycle k+2.
- Next `start` is accepted in cycle k+3 at the earliest.
- k=0: `done` in cycle 2 with `result`=`operand`.
- k=31 (no macro): `done` in cycle 33.
- `busy` is high in cycles 1..k+2 inclusive.

## Configuration
- `ITER_SHIFT_STRIDE4_EN`
  - Defined: in SHIFT, when `cnt`≥4, one cycle shifts by 4 (same fill rules) and `cnt` decrements by 4. Otherwise the step is 1.
  - Defined: step count is floor(k/4)+(k mod 4); `done` in cycle floor(k/4)+(k mod 4)+2.
  - Defined examples: k=31 gives `done` in cycle 12; k=4 gives cycle 3.
  - Undefined: only 1-bit steps; base latency applies.
  - `result` values are identical in both builds.

## Test plan
- Reset, then idle 5 cycles -> `busy`=0, `done`=0, `result`=0x00000000 throughout.
- SLL, `operand`=0x00000001, `shamt`=31 -> `result`=0x80000000.
  - Without macro: `done` in cycle 33.
  - With macro: `done` in cycle 12.
  - `done` high exactly one cycle.
- SRA, `operand`=0x80000000, `shamt`=4 -> `result`=0xF8000000, `done` cycle 6 (cycle 3 with macro). Repeat as SRL -> 0x08000000.
- `shamt`=0, `operand`=0xDEADBEEF -> `result`=0xDEADBEEF, `done` cycle 2.
  - Assert `start` again in cycle 1 with `operand`=0x12345678: it is ignored and `result` stays 0xDEADBEEF.
- Start SLL with `shamt`=20, assert `flush` in cycle 5:
  - IDLE in cycle 6, no `done`.
  - `result` keeps its previous value.
  - A new `start` in cycle 6 completes normally.
- Start SRL with `shamt`=10, assert `rst` in cycle 4:
  - Outputs are 0 immediately.
  - After release, a new `start` with `shamt`=1, `operand`=0x2 gives `result`=0x1 in cycle 3.

Source files
------------

// File: rtl/iter_shift_ctrl.sv
// Iterative SLL/SRL/SRA sequencer: latches operand and amount, shifts one bit per cycle.
// Build macro ITER_SHIFT_STRIDE4_EN enables 4-bit steps while the remaining count is >= 4.
module iter_shift_ctrl #(
    parameter int N   = 32,
    parameter int SHW = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [1:0]     op,
    input  logic [N-1:0]   operand,
    input  logic [SHW-1:0] shamt,
    input  logic           flush,
    output logic           busy,
    output logic           done,
    output logic [N-1:0]   result,
    output logic [1:0]     dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_next_state;
    logic [N-1:0]   r_data;
    logic [SHW-1:0] r_cnt;
    logic [1:0]     r_op;
    logic [N-1:0]   r_result;

    logic [N-1:0]   w_sh1;
    logic [N-1:0]   w_step_data;
    logic [SHW-1:0] w_step_amt;

    // Single-bit step; op 2'b11 falls through to SLL.
    always_comb begin
        case (r_op)
            2'b01:   w_sh1 = {1'b0, r_data[N-1:1]};
            2'b10:   w_sh1 = {r_data[N-1], r_data[N-1:1]};
            default: w_sh1 = {r_data[N-2:0], 1'b0};
        endcase
    end

`ifdef ITER_SHIFT_STRIDE4_EN
    logic [N-1:0] w_sh4;

    always_comb begin
        case (r_op)
            2'b01:   w_sh4 = {4'b0000, r_data[N-1:4]};
            2'b10:   w_sh4 = {{4{r_data[N-1]}}, r_data[N-1:4]};
            default: w_sh4 = {r_data[N-5:0], 4'b0000};
        endcase
    end

    always_comb begin
        if (r_cnt >= SHW'(4)) begin
            w_step_data = w_sh4;
            w_step_amt  = SHW'(4);
        end else begin
            w_step_data = w_sh1;
            w_step_amt  = SHW'(1);
        end
    end
`else
    always_comb begin
        w_step_data = w_sh1;
        w_step_amt  = SHW'(1);
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Flush wins over everything, including a same-cycle start.
    always_comb begin
        w_next_state = r_state;
        if (flush) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (start) w_next_state = S_SHIFT;
                S_SHIFT: if (r_cnt == '0) w_next_state = S_DONE;
                S_DONE:  w_next_state = S_IDLE;
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy      = (r_state != S_IDLE);
        done      = (r_state == S_DONE);
        result    = r_result;
        dbg_state = r_state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data   <= '0;
            r_cnt    <= '0;
            r_op     <= 2'b00;
            r_result <= '0;
        end else if (!flush) begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_data <= operand;
                        r_cnt  <= shamt;
                        r_op   <= op;
                    end
                end
                S_SHIFT: begin
                    if (r_cnt != '0) begin
                        r_data <= w_step_data;
                        r_cnt  <= r_cnt - w_step_amt;
                    end else begin
                        r_result <= r_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
